// File: rtl/encrypt_v2_pkg.sv
// Shared constants, FSM state type and the PRESENT S-box for the encrypt_v2 core.
// The S-box lives here so v1 and a future decrypt core can reuse it.
package encrypt_v2_pkg;

  localparam int N_B         = 64;
  localparam int N_R         = 31;
  localparam int N_K_DEFAULT = 80;
  localparam int N_V         = 6;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  function automatic logic [3:0] present_sbox(input logic [3:0] x);
    logic [3:0] y;
    unique case (x)
      4'h0: y = 4'hC;
      4'h1: y = 4'h5;
      4'h2: y = 4'h6;
      4'h3: y = 4'hB;
      4'h4: y = 4'h9;
      4'h5: y = 4'h0;
      4'h6: y = 4'hA;
      4'h7: y = 4'hD;
      4'h8: y = 4'h3;
      4'h9: y = 4'hE;
      4'hA: y = 4'hF;
      4'hB: y = 4'h8;
      4'hC: y = 4'h4;
      4'hD: y = 4'h7;
      4'hE: y = 4'h1;
      default: y = 4'h2;
    endcase
    return y;
  endfunction

endpackage

// File: rtl/encrypt_v2_round.sv
// One combinational PRESENT round: round-key add, S-box layer, bit permutation,
// and the matching key-schedule step for an 80- or 128-bit key register.
module present_round
  import encrypt_v2_pkg::*;
#(
  parameter int N_K = N_K_DEFAULT
) (
  input  logic [N_B-1:0] s,
  input  logic [N_K-1:0] key,
  input  logic [4:0]     i,
  output logic [N_B-1:0] s_next,
  output logic [N_K-1:0] key_next
);

  logic [N_B-1:0] mixed;
  logic [N_B-1:0] subbed;
  logic [N_K-1:0] rotated;

  always_comb begin
    mixed  = s ^ key[N_K-1 -: N_B];
    subbed = '0;
    for (int n = 0; n < N_B / 4; n++) begin
      subbed[4*n +: 4] = present_sbox(mixed[4*n +: 4]);
    end
  end

  // Bit j moves to 16*j mod 63; the top bit maps onto itself.
  always_comb begin
    s_next = '0;
    for (int j = 0; j < N_B - 1; j++) begin
      s_next[(16 * j) % (N_B - 1)] = subbed[j];
    end
    s_next[N_B-1] = subbed[N_B-1];
  end

  assign rotated = {key[N_K-62:0], key[N_K-1 -: 61]};

  generate
    if (N_K == 80) begin : g_k80
      always_comb begin
        key_next          = rotated;
        key_next[79:76]   = present_sbox(rotated[79:76]);
        key_next[19:15]   = rotated[19:15] ^ i;
      end
    end else begin : g_k128
      always_comb begin
        key_next          = rotated;
        key_next[127:124] = present_sbox(rotated[127:124]);
        key_next[123:120] = present_sbox(rotated[123:120]);
        key_next[66:62]   = rotated[66:62] ^ i;
      end
    end
  endgenerate

endmodule

// File: rtl/encrypt_v2.sv
// Iterative PRESENT encryption core, UNROLL rounds per clock, req/ack handshake.
// Optional debug port rk (final key-schedule state) with ENCRYPT_V2_RK_EN.
module encrypt_v2
  import encrypt_v2_pkg::*;
#(
  parameter int N_K    = N_K_DEFAULT,
  parameter int UNROLL = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req,
  output logic           ack,
  input  logic [N_K-1:0] k,
  input  logic [N_B-1:0] m,
  output logic [N_B-1:0] c
`ifdef ENCRYPT_V2_RK_EN
  ,
  output logic [N_K-1:0] rk
`endif
);

  generate
    if (N_K != 80 && N_K != 128) begin : g_bad_nk
      $error("encrypt_v2: N_K must be 80 or 128, got %0d", N_K);
    end
    if (UNROLL < 1 || UNROLL > N_R) begin : g_bad_unroll
      $error("encrypt_v2: UNROLL must be 1..31, got %0d", UNROLL);
    end
  endgenerate

  state_t         state;
  logic [4:0]     r;
  logic [N_B-1:0] s_q;
  logic [N_K-1:0] key_q;
  logic [N_B-1:0] s_fin;
  logic [N_K-1:0] key_fin;
  logic           last_pass;

  // Stage g handles round r+g; stages past round 31 pass their input through.
  for (genvar g = 0; g < UNROLL; g++) begin : g_stage
    logic [N_B-1:0] s_in;
    logic [N_B-1:0] s_rnd;
    logic [N_B-1:0] s_out;
    logic [N_K-1:0] k_in;
    logic [N_K-1:0] k_rnd;
    logic [N_K-1:0] k_out;
    logic [5:0]     idx;

    if (g == 0) begin : g_first
      assign s_in = s_q;
      assign k_in = key_q;
    end else begin : g_next
      assign s_in = g_stage[g-1].s_out;
      assign k_in = g_stage[g-1].k_out;
    end

    assign idx = 6'(r) + 6'(g);

    present_round #(.N_K(N_K)) u_round (
      .s        (s_in),
      .key      (k_in),
      .i        (idx[4:0]),
      .s_next   (s_rnd),
      .key_next (k_rnd)
    );

    assign s_out = (idx <= 6'(N_R)) ? s_rnd : s_in;
    assign k_out = (idx <= 6'(N_R)) ? k_rnd : k_in;
  end

  assign s_fin     = g_stage[UNROLL-1].s_out;
  assign key_fin   = g_stage[UNROLL-1].k_out;
  assign last_pass = (int'(r) + UNROLL > N_R);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ack   <= 1'b0;
      c     <= '0;
      r     <= '0;
      s_q   <= '0;
      key_q <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req) begin
            s_q   <= m;
            key_q <= k;
            r     <= 5'd1;
            state <= RUN;
          end
        end
        RUN: begin
          s_q   <= s_fin;
          key_q <= key_fin;
          if (last_pass) begin
            c     <= s_fin ^ key_fin[N_K-1 -: N_B];
            ack   <= 1'b1;
            r     <= '0;
            state <= DONE;
          end else begin
            r <= r + 5'(UNROLL);
          end
        end
        DONE: begin
          // Host must see ack and drop req before another block is taken.
          if (!req) begin
            ack   <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ENCRYPT_V2_RK_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      rk <= '0;
    end else if (state == RUN && last_pass) begin
      rk <= key_fin;
    end
  end
`endif

endmodule

// File: tb/tb_encrypt_v2.sv
// Self-checking bench for encrypt_v2: five parameterisations run side by side
// against a bit-level PRESENT model, with handshake and reset corner cases.
module tb_encrypt_v2;

  localparam int N_DUT = 5;

  typedef struct {
    logic [127:0] k;
    logic [63:0]  m;
    logic [63:0]  e80;
    logic [63:0]  e128;
    logic [127:0] r80;
    logic [127:0] r128;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         req;
  logic [127:0] kk;
  logic [63:0]  m;
  logic         ack [N_DUT];
  logic [63:0]  c   [N_DUT];
`ifdef ENCRYPT_V2_RK_EN
  logic [79:0]  rk80  [3];
  logic [127:0] rk128 [2];
`endif

  vec_t tbl [6];
  vec_t sb [$];
  int   lat [N_DUT];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  encrypt_v2 #(.N_K(80), .UNROLL(1)) d0 (
    .clk(clk), .rst(rst), .req(req), .ack(ack[0]), .k(kk[79:0]), .m(m), .c(c[0])
`ifdef ENCRYPT_V2_RK_EN
    , .rk(rk80[0])
`endif
  );
  encrypt_v2 #(.N_K(80), .UNROLL(4)) d1 (
    .clk(clk), .rst(rst), .req(req), .ack(ack[1]), .k(kk[79:0]), .m(m), .c(c[1])
`ifdef ENCRYPT_V2_RK_EN
    , .rk(rk80[1])
`endif
  );
  encrypt_v2 #(.N_K(80), .UNROLL(31)) d2 (
    .clk(clk), .rst(rst), .req(req), .ack(ack[2]), .k(kk[79:0]), .m(m), .c(c[2])
`ifdef ENCRYPT_V2_RK_EN
    , .rk(rk80[2])
`endif
  );
  encrypt_v2 #(.N_K(128), .UNROLL(1)) d3 (
    .clk(clk), .rst(rst), .req(req), .ack(ack[3]), .k(kk), .m(m), .c(c[3])
`ifdef ENCRYPT_V2_RK_EN
    , .rk(rk128[0])
`endif
  );
  encrypt_v2 #(.N_K(128), .UNROLL(5)) d4 (
    .clk(clk), .rst(rst), .req(req), .ack(ack[4]), .k(kk), .m(m), .c(c[4])
`ifdef ENCRYPT_V2_RK_EN
    , .rk(rk128[1])
`endif
  );

  // ceil(31/UNROLL) RUN edges plus the edge that samples req.
  function automatic int exp_lat(input int d);
    case (d)
      0: return 32;
      1: return 9;
      2: return 2;
      3: return 32;
      default: return 8;
    endcase
  endfunction

  function automatic logic [3:0] sb4(input logic [3:0] x);
    logic [63:0] table_bits;
    table_bits = 64'h21748FE3DA09B65C;
    return table_bits[4*x +: 4];
  endfunction

  function automatic logic [63:0] model_enc(input logic [127:0] key, input logic [63:0] pt,
                                            input bit wide, output logic [127:0] k32);
    logic [79:0]  a;
    logic [127:0] b;
    logic [63:0]  s;
    logic [63:0]  t;
    a = key[79:0];
    b = key;
    s = pt;
    for (int i = 1; i <= 31; i++) begin
      s = s ^ (wide ? b[127:64] : a[79:16]);
      for (int n = 0; n < 16; n++) s[4*n +: 4] = sb4(s[4*n +: 4]);
      t = '0;
      for (int j = 0; j < 63; j++) t[(16 * j) % 63] = s[j];
      t[63] = s[63];
      s = t;
      if (wide) begin
        b = (b << 61) | (b >> 67);
        b[127:124] = sb4(b[127:124]);
        b[123:120] = sb4(b[123:120]);
        b[66:62]   = b[66:62] ^ 5'(i);
      end else begin
        a = (a << 61) | (a >> 19);
        a[79:76] = sb4(a[79:76]);
        a[19:15] = a[19:15] ^ 5'(i);
      end
    end
    k32 = wide ? b : {48'b0, a};
    return s ^ (wide ? b[127:64] : a[79:16]);
  endfunction

  task automatic checkValue(input string name, input int d, input logic [127:0] act,
                            input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s dut%0d actual %h required %h", name, d, act, exp);
    end
  endtask

  task automatic applyStimulus(input int idx);
    @(negedge clk);
    kk  = tbl[idx].k;
    m   = tbl[idx].m;
    req = 1'b1;
    sb.push_back(tbl[idx]);
  endtask

  // Count edges from the req-sampling edge until each ack is seen high.
  task automatic waitAcks();
    int  n;
    bool_loop: begin end
    for (int d = 0; d < N_DUT; d++) lat[d] = 0;
    @(posedge clk);
    n = 1;
    for (int cyc = 0; cyc < 60; cyc++) begin
      bit all_seen;
      @(negedge clk);
      all_seen = 1'b1;
      for (int d = 0; d < N_DUT; d++) begin
        if (ack[d] && lat[d] == 0) lat[d] = n;
        if (lat[d] == 0) all_seen = 1'b0;
      end
      if (all_seen) break;
      @(posedge clk);
      n++;
    end
  endtask

  task automatic checkOutput();
    vec_t e;
    e = sb.pop_front();
    for (int d = 0; d < N_DUT; d++) begin
      checkValue("ciphertext", d, {64'b0, c[d]}, {64'b0, (d >= 3) ? e.e128 : e.e80});
      checkValue("latency", d, 128'(lat[d]), 128'(exp_lat(d)));
    end
`ifdef ENCRYPT_V2_RK_EN
    for (int d = 0; d < 3; d++) checkValue("rk", d, {48'b0, rk80[d]}, e.r80);
    for (int d = 0; d < 2; d++) checkValue("rk", d + 3, rk128[d], e.r128);
`endif
  endtask

  task automatic releaseReq();
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    for (int d = 0; d < N_DUT; d++) checkValue("ack_drop", d, {127'b0, ack[d]}, 128'd0);
  endtask

  initial begin
    rst = 1'b1;
    req = 1'b0;
    kk  = '0;
    m   = '0;

    for (int i = 0; i < 6; i++) begin
      if (i == 0) begin
        tbl[i].k = '0;
        tbl[i].m = '0;
      end else if (i == 1) begin
        tbl[i].k = '1;
        tbl[i].m = '1;
      end else begin
        tbl[i].k = {$urandom(), $urandom(), $urandom(), $urandom()};
        tbl[i].m = {$urandom(), $urandom()};
      end
      tbl[i].e80  = model_enc({48'b0, tbl[i].k[79:0]}, tbl[i].m, 1'b0, tbl[i].r80);
      tbl[i].e128 = model_enc(tbl[i].k, tbl[i].m, 1'b1, tbl[i].r128);
    end
    // Published known-answer vectors take precedence over the model.
    tbl[0].e80  = 64'h5579c1387b228445;
    tbl[0].e128 = 64'h96db702a2e6900af;
    tbl[1].e80  = 64'h3333dcd3213210d2;

    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < N_DUT; d++) begin
      checkValue("reset_ack", d, {127'b0, ack[d]}, 128'd0);
      checkValue("reset_c", d, {64'b0, c[d]}, 128'd0);
    end
    rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      if (i == 3) continue;
      applyStimulus(i);
      waitAcks();
      checkOutput();
      if (i == 0) begin
        // req held in DONE: ack stays up, c holds, new k/m ignored.
        kk = {$urandom(), $urandom(), $urandom(), $urandom()};
        m  = {$urandom(), $urandom()};
        repeat (5) begin
          @(negedge clk);
          for (int d = 0; d < N_DUT; d++) begin
            checkValue("hold_ack", d, {127'b0, ack[d]}, 128'd1);
            checkValue("hold_c", d, {64'b0, c[d]}, {64'b0, (d >= 3) ? tbl[0].e128 : tbl[0].e80});
          end
        end
      end
      releaseReq();
    end

    // Reset in the middle of a run discards the operation.
    applyStimulus(2);
    @(posedge clk);
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    req = 1'b0;
    @(negedge clk);
    for (int d = 0; d < N_DUT; d++) begin
      checkValue("midrst_ack", d, {127'b0, ack[d]}, 128'd0);
      checkValue("midrst_c", d, {64'b0, c[d]}, 128'd0);
    end
    void'(sb.pop_front());
    rst = 1'b0;

    applyStimulus(3);
    waitAcks();
    checkOutput();
    releaseReq();

    // req dropped during the first RUN cycle: ack pulses for one cycle only.
    begin
      int          hi [N_DUT];
      logic [63:0] cap [N_DUT];
      vec_t        e;
      applyStimulus(4);
      @(posedge clk);
      @(negedge clk);
      req = 1'b0;
      for (int d = 0; d < N_DUT; d++) begin
        hi[d]  = 0;
        cap[d] = '0;
      end
      repeat (40) begin
        @(negedge clk);
        for (int d = 0; d < N_DUT; d++) begin
          if (ack[d]) begin
            hi[d]++;
            cap[d] = c[d];
          end
        end
      end
      e = sb.pop_front();
      for (int d = 0; d < N_DUT; d++) begin
        checkValue("drop_ack_cycles", d, 128'(hi[d]), 128'd1);
        checkValue("drop_c", d, {64'b0, cap[d]}, {64'b0, (d >= 3) ? e.e128 : e.e80});
      end
`ifdef ENCRYPT_V2_RK_EN
      for (int d = 0; d < 3; d++) checkValue("drop_rk", d, {48'b0, rk80[d]}, e.r80);
      for (int d = 0; d < 2; d++) checkValue("drop_rk", d + 3, rk128[d], e.r128);
`endif
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
